// File: rtl/sisc_fetch.sv
// SISC instruction fetch stage: owns the PC, reads instruction memory over a req/ack
// handshake and hands the latched word to the core as ir/ir_valid.
module sisc_fetch #(
    parameter int unsigned             ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]       RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_f,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ack,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    output logic [31:0]       ir,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       fetch_cnt
);

    typedef enum logic [1:0] {
        FETCH_PEND,
        FETCH,
        HOLD
    } state_t;

    state_t            r_state;
    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_ir;
    logic              r_ir_valid;
    logic [15:0]       r_cnt;
    logic              r_redir;
    logic [ADDR_W-1:0] r_redir_addr;
    logic [ADDR_W-1:0] w_pc_inc;

    assign w_pc_inc = r_pc + ADDR_W'(1);

    // r_addr doubles as the pending fetch address and the live request address;
    // it only moves outside an outstanding request, keeping imem_addr stable until ack.
    always_ff @(posedge clk) begin
        if (rst_f) begin
            r_state      <= FETCH_PEND;
            r_req        <= 1'b0;
            r_addr       <= RESET_PC;
            r_pc         <= RESET_PC;
            r_ir         <= '0;
            r_ir_valid   <= 1'b0;
            r_cnt        <= '0;
            r_redir      <= 1'b0;
            r_redir_addr <= RESET_PC;
        end else begin
            case (r_state)
                FETCH_PEND: begin
                    r_req   <= 1'b1;
                    r_state <= FETCH;
                    if (br_taken) begin
                        r_addr <= br_addr;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        r_req <= 1'b0;
                        if (r_redir || br_taken) begin
                            // Word belongs to the abandoned path; a same-cycle branch is the newest target.
                            r_addr  <= br_taken ? br_addr : r_redir_addr;
                            r_redir <= 1'b0;
                            r_state <= FETCH_PEND;
                        end else begin
                            r_ir       <= imem_rdata;
                            r_pc       <= r_addr;
                            r_ir_valid <= 1'b1;
                            r_state    <= HOLD;
                        end
                    end else if (br_taken) begin
                        r_redir      <= 1'b1;
                        r_redir_addr <= br_addr;
                    end
                end
                HOLD: begin
                    if (br_taken) begin
                        r_ir_valid <= 1'b0;
                        r_addr     <= br_addr;
                        r_state    <= FETCH_PEND;
                    end else if (!stall) begin
                        r_ir_valid <= 1'b0;
                        r_cnt      <= r_cnt + 16'd1;
                        r_addr     <= w_pc_inc;
                        r_state    <= FETCH_PEND;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= FETCH_PEND;
                end
            endcase
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign ir        = r_ir;
    assign ir_valid  = r_ir_valid;
    assign pc        = r_pc;
    assign fetch_cnt = r_cnt;

endmodule

// File: tb/tb_sisc_fetch.sv
// Bench for sisc_fetch: directed scenarios plus a randomized run checked against an
// event-timestamp reference model of the fetch protocol.
module tb_sisc_fetch;

    logic        clk = 1'b0;
    logic        rst_f = 1'b1;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] br_addr = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;

    logic        imem_req, ir_valid;
    logic [15:0] imem_addr, pc, fetch_cnt;
    logic [31:0] ir;

    logic        b_req, b_valid;
    logic [15:0] b_addr, b_pc, b_cnt;
    logic [31:0] b_ir;

    int          checks = 0;
    int          errors = 0;

    // memory model controls
    int          mem_wait = 0;      // <0: random 0..3 wait cycles
    logic        stray_en = 1'b0;
    logic        force_ack = 1'b0;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_word = '0;
    logic        in_req = 1'b0;
    int          left = 0;

    sisc_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_f(rst_f), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack), .stall(stall), .br_taken(br_taken),
        .br_addr(br_addr), .ir(ir), .ir_valid(ir_valid), .pc(pc), .fetch_cnt(fetch_cnt)
    );

    sisc_fetch #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut2 (
        .clk(clk), .rst_f(rst_f), .imem_req(b_req), .imem_addr(b_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack), .stall(stall), .br_taken(br_taken),
        .br_addr(br_addr), .ir(b_ir), .ir_valid(b_valid), .pc(b_pc), .fetch_cnt(b_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return 32'h1000_0000 + {16'h0000, a};
    endfunction

    // Instruction memory: answers dut's request after a programmable wait.
    always @(negedge clk) begin
        if (force_ack) begin
            imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; in_req = 1'b0;
        end else if (imem_req && !rst_f) begin
            if (!in_req) begin
                in_req = 1'b1;
                left = (mem_wait < 0) ? int'($urandom_range(3, 0)) : mem_wait;
            end
            if (left == 0) begin
                imem_ack = 1'b1; imem_rdata = ovr_en ? ovr_word : mem_word(imem_addr); in_req = 1'b0;
            end else begin
                imem_ack = 1'b0; imem_rdata = $urandom; left--;
            end
        end else begin
            in_req = 1'b0;
            imem_ack = stray_en && ($urandom_range(3, 0) == 0);
            imem_rdata = $urandom;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_f = 1'b1; br_taken = 1'b0; stall = 1'b0;
        tick(); tick();
        rst_f = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (ir_valid) begin n = i; break; end
        end
    endtask

    task automatic test_reset();
        rst_f = 1'b1; stray_en = 1'b1; mem_wait = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({imem_req, ir_valid, fetch_cnt, imem_addr, ir} !== {1'b0, 1'b0, 16'h0, 16'h0, 32'h0}) begin
                errors++;
                $display("FAIL reset_state: req=%b valid=%b cnt=%h addr=%h ir=%h, want all zero",
                         imem_req, ir_valid, fetch_cnt, imem_addr, ir);
            end
        end
        rst_f = 1'b0;
        tick();
        checks++;
        if ({imem_req, imem_addr, ir_valid} !== {1'b1, 16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL reset_first_req: req=%b addr=%h valid=%b, want 1 0000 0", imem_req, imem_addr, ir_valid);
        end
        stray_en = 1'b0;
    endtask

    task automatic test_zero_wait();
        int n;
        do_reset(); mem_wait = 0;
        for (int k = 0; k < 3; k++) begin
            wait_valid(n);
            checks++;
            if (n != (k == 0 ? 2 : 3)) begin
                errors++;
                $display("FAIL zw_latency[%0d]: cycles=%0d want %0d", k, n, (k == 0 ? 2 : 3));
            end
            checks++;
            if (ir !== mem_word(16'(k)) || pc !== 16'(k)) begin
                errors++;
                $display("FAIL zw_ir[%0d]: ir=%h pc=%h want %h %h", k, ir, pc, mem_word(16'(k)), 16'(k));
            end
        end
        tick();
        checks++;
        if (fetch_cnt !== 16'd3) begin
            errors++;
            $display("FAIL zw_count: fetch_cnt=%0d want 3", fetch_cnt);
        end
    endtask

    task automatic test_wait_states();
        do_reset(); stall = 1'b1; mem_wait = 2;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if ({imem_req, imem_addr, ir_valid} !== {1'b1, 16'h0000, 1'b0}) begin
                errors++;
                $display("FAIL ws_wait[%0d]: req=%b addr=%h valid=%b want 1 0000 0", i, imem_req, imem_addr, ir_valid);
            end
        end
        tick();
        checks++;
        if ({ir_valid, imem_req, ir} !== {1'b1, 1'b0, 32'h1000_0000}) begin
            errors++;
            $display("FAIL ws_data: valid=%b req=%b ir=%h want 1 0 10000000", ir_valid, imem_req, ir);
        end
        stall = 1'b0;
        tick();
        checks++;
        if ({fetch_cnt, ir_valid, imem_req} !== {16'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ws_consume: cnt=%0d valid=%b req=%b want 1 0 0", fetch_cnt, ir_valid, imem_req);
        end
        stall = 1'b1;
        tick();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0001}) begin
            errors++;
            $display("FAIL ws_next: req=%b addr=%h want 1 0001", imem_req, imem_addr);
        end
    endtask

    task automatic test_stall();
        int n;
        do_reset(); mem_wait = 0; stall = 1'b1;
        ovr_en = 1'b1; ovr_word = 32'h2112_0005;
        wait_valid(n);
        ovr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({ir, pc, ir_valid, imem_req, fetch_cnt} !== {32'h2112_0005, 16'h0, 1'b1, 1'b0, 16'h0}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: ir=%h pc=%h valid=%b req=%b cnt=%0d want 21120005 0000 1 0 0",
                         i, ir, pc, ir_valid, imem_req, fetch_cnt);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if ({fetch_cnt, ir_valid} !== {16'd1, 1'b0}) begin
            errors++;
            $display("FAIL stall_release: cnt=%0d valid=%b want 1 0", fetch_cnt, ir_valid);
        end
    endtask

    task automatic test_branch_fetch();
        int n;
        bit found;
        do_reset(); mem_wait = 0; stall = 1'b1;
        wait_valid(n);
        mem_wait = 3; br_taken = 1'b1; br_addr = 16'h0005;
        tick();
        br_taken = 1'b0;
        checks++;
        if ({ir_valid, imem_req, fetch_cnt} !== {1'b0, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL br_hold: valid=%b req=%b cnt=%0d want 0 0 0", ir_valid, imem_req, fetch_cnt);
        end
        tick();
        br_taken = 1'b1; br_addr = 16'h0040;
        tick();
        br_taken = 1'b0;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0005}) begin
            errors++;
            $display("FAIL br_addr_stable: req=%b addr=%h want 1 0005", imem_req, imem_addr);
        end
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            if (imem_req && imem_addr == 16'h0040) found = 1;
            checks++;
            if (ir_valid !== 1'b0) begin
                errors++;
                $display("FAIL br_discard: valid=%b pc=%h want 0", ir_valid, pc);
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL br_redirect_timeout: addr=%h want request at 0040", imem_addr);
        end
        wait_valid(n);
        checks++;
        if ({pc, ir, 1'(n > 0)} !== {16'h0040, 32'h1000_0040, 1'b1}) begin
            errors++;
            $display("FAIL br_target: pc=%h ir=%h n=%0d want 0040 10000040", pc, ir, n);
        end
    endtask

    task automatic test_wrap();
        bit seen = 0;
        do_reset(); mem_wait = 0; stall = 1'b0;
        ovr_en = 1'b1; ovr_word = 32'hCAFE_0001;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (b_valid) seen = 1;
        end
        ovr_en = 1'b0;
        checks++;
        if ({1'(seen), b_pc, b_ir} !== {1'b1, 16'hFFFF, 32'hCAFE_0001}) begin
            errors++;
            $display("FAIL wrap_first: seen=%b pc=%h ir=%h want 1 FFFF CAFE0001", seen, b_pc, b_ir);
        end
        tick();
        tick();
        checks++;
        if ({b_req, b_addr, b_cnt} !== {1'b1, 16'h0000, 16'd1}) begin
            errors++;
            $display("FAIL wrap_next: req=%b addr=%h cnt=%0d want 1 0000 1", b_req, b_addr, b_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset(); mem_wait = 0; stall = 1'b0;
        wait_valid(n);
        mem_wait = 5;
        tick(); tick();
        rst_f = 1'b1;
        tick();
        checks++;
        if ({imem_req, imem_addr, ir_valid, fetch_cnt} !== {1'b0, 16'h0, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL rstmid_state: req=%b addr=%h valid=%b cnt=%0d want 0 0000 0 0",
                     imem_req, imem_addr, ir_valid, fetch_cnt);
        end
        rst_f = 1'b0; force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({imem_req, imem_addr, ir_valid} !== {1'b1, 16'h0, 1'b0}) begin
                errors++;
                $display("FAIL rstmid_late_ack[%0d]: req=%b addr=%h valid=%b want 1 0000 0",
                         i, imem_req, imem_addr, ir_valid);
            end
            tick();
        end
    endtask

    // Reference: each event schedules the cycles where outputs must show a given value.
    task automatic test_random();
        int          c, idle_c, req_c, val_c;
        logic [15:0] m_fetch, m_pc, m_tgt, last_addr, a_s;
        logic [31:0] m_ir;
        logic [15:0] m_cnt;
        logic        m_pend, prev_req, req_s, val_s, ack;
        do_reset(); mem_wait = -1; stray_en = 1'b1;
        c = 0; idle_c = 0; req_c = 1; val_c = -1;
        m_fetch = 16'h0; m_pc = 16'h0; m_tgt = 16'h0; m_ir = '0; m_cnt = '0;
        m_pend = 0; prev_req = 0; last_addr = '0;
        for (int it = 0; it < 1500; it++) begin
            req_s = imem_req; val_s = ir_valid; a_s = imem_addr;
            checks++;
            if (fetch_cnt !== m_cnt) begin
                errors++; $display("FAIL rnd_cnt@%0d: %0d want %0d", c, fetch_cnt, m_cnt);
            end
            if (c == idle_c) begin
                checks++;
                if ({req_s, val_s} !== 2'b00) begin
                    errors++; $display("FAIL rnd_idle@%0d: req=%b valid=%b want 0 0", c, req_s, val_s);
                end
            end
            if (c == req_c) begin
                checks++;
                if ({req_s, a_s} !== {1'b1, m_fetch}) begin
                    errors++; $display("FAIL rnd_req@%0d: req=%b addr=%h want 1 %h", c, req_s, a_s, m_fetch);
                end
            end
            if (req_s && prev_req) begin
                checks++;
                if (a_s !== last_addr) begin
                    errors++; $display("FAIL rnd_addr_hold@%0d: addr=%h want %h", c, a_s, last_addr);
                end
            end
            if (c == val_c) begin
                checks++;
                if ({val_s, ir, pc} !== {1'b1, m_ir, m_pc}) begin
                    errors++; $display("FAIL rnd_ir@%0d: valid=%b ir=%h pc=%h want 1 %h %h", c, val_s, ir, pc, m_ir, m_pc);
                end
            end
            stall = ($urandom_range(2, 0) == 0);
            br_taken = ($urandom_range(7, 0) == 0);
            br_addr = 16'($urandom);
            @(negedge clk); #1;
            ack = imem_ack;
            if (req_s) begin
                if (ack) begin
                    if (m_pend || br_taken) begin
                        m_fetch = br_taken ? br_addr : m_tgt;
                        m_pend = 0; idle_c = c + 1; req_c = c + 2;
                    end else begin
                        m_ir = mem_word(m_fetch); m_pc = m_fetch; val_c = c + 1;
                    end
                end else if (br_taken) begin
                    m_tgt = br_addr; m_pend = 1;
                end
            end else if (val_s) begin
                if (br_taken) begin
                    m_fetch = br_addr; idle_c = c + 1; req_c = c + 2;
                end else if (!stall) begin
                    m_cnt = m_cnt + 16'd1; m_fetch = m_pc + 16'd1; idle_c = c + 1; req_c = c + 2;
                end else begin
                    val_c = c + 1;
                end
            end else if (br_taken) begin
                m_fetch = br_addr;
            end
            prev_req = req_s; last_addr = a_s;
            tick();
            c++;
        end
        br_taken = 1'b0; stall = 1'b0; stray_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_branch_fetch();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
